// File: rtl/div_seq_pkg.sv
// div_seq_pkg: shared definitions for the DIV/DIVU sequencer.
//   - div_state_e : sequencer states
//   - result/start/stall/reset level constants
//   - double_reg_t: 64-bit {remainder, quotient} bus type
//   - neg32       : two's-complement negate, mod 2^32
// Optional feature macro used by importers: DIV_SIGNED_EN.
package div_seq_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE    = 2'd0,
    DIV_DIVZERO = 2'd1,
    DIV_ON      = 2'd2,
    DIV_END     = 2'd3
  } div_state_e;

  localparam logic        RST_ENABLE           = 1'b1;
  localparam logic        DIV_RESULT_READY     = 1'b1;
  localparam logic        DIV_RESULT_NOT_READY = 1'b0;
  localparam logic        DIV_START            = 1'b1;
  localparam logic        DIV_STOP             = 1'b0;
  localparam logic        STALLREQ_ENABLE      = 1'b1;
  localparam logic        STALLREQ_DISABLE     = 1'b0;
  localparam logic [31:0] ZERO_WORD            = 32'h0000_0000;
  localparam int          DOUBLE_REG_BUS       = 64;

  typedef logic [DOUBLE_REG_BUS-1:0] double_reg_t;

  // 0x80000000 maps to itself, which is the magnitude the datapath expects.
  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ZERO_WORD - v;
  endfunction

endpackage

// File: rtl/div_seq_if.sv
// div_seq_if: EX <-> divider handshake bundle.
//   start_i, signed_i, opdata1_i, opdata2_i, annul_i : request side (EX/ctrl drive)
//   result_o, ready_o, stallreq_o                    : divider responses
// Modports: slave (divider), master (EX / testbench).
interface div_seq_if;
  import div_seq_pkg::*;

  logic        start_i;
  logic        signed_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        annul_i;
  double_reg_t result_o;
  logic        ready_o;
  logic        stallreq_o;

  modport slave (
    input  start_i, signed_i, opdata1_i, opdata2_i, annul_i,
    output result_o, ready_o, stallreq_o
  );

  modport master (
    output start_i, signed_i, opdata1_i, opdata2_i, annul_i,
    input  result_o, ready_o, stallreq_o
  );

endinterface

// File: rtl/div_seq_step.sv
// div_step: one combinational restoring shift-subtract step.
//   rem_i     : 32-bit partial remainder (always < divisor_i)
//   bit_i     : next dividend bit shifted in
//   divisor_i : 32-bit divisor magnitude
//   rem_o     : updated partial remainder
//   q_o       : quotient bit produced by this step
module div_step (
  input  logic [31:0] rem_i,
  input  logic        bit_i,
  input  logic [31:0] divisor_i,
  output logic [31:0] rem_o,
  output logic        q_o
);

  logic [32:0] diff;

  // Because rem_i < divisor_i, {rem_i, bit_i} < 2*divisor_i, so bit 32 of the
  // 33-bit difference is exactly the borrow (negative result).
  assign diff  = {rem_i, bit_i} - {1'b0, divisor_i};
  assign q_o   = ~diff[32];
  assign rem_o = q_o ? diff[31:0] : {rem_i[30:0], bit_i};

endmodule

// File: rtl/div_seq.sv
// div_seq: multi-cycle DIV/DIVU sequencer beside the EX stage.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : div_seq_if.slave (start/signed/operands/annul in;
//          result {rem, quot}, one-cycle ready, stall request out)
// Parameter DIV_ITER: iteration count, equals operand width (32).
// Macro DIV_SIGNED_EN: when defined, signed_i selects DIV with magnitude
// preprocessing and sign correction; otherwise everything is unsigned.
//
// state       | meaning
// DIV_IDLE    | waiting for start; operands sampled on accept
// DIV_DIVZERO | divisor was zero; canned result already loaded
// DIV_ON      | one restoring step per cycle, DIV_ITER cycles
// DIV_END     | ready_o pulse, result driven, back to IDLE
module div_seq
  import div_seq_pkg::*;
#(
  parameter int unsigned DIV_ITER = 32
) (
  input logic       clk,
  input logic       rst,
  div_seq_if.slave  bus
);

  localparam logic [4:0] LAST_STEP = 5'(DIV_ITER - 1);

  div_state_e  state_q, state_d;
  logic [4:0]  cnt_q;
  logic [31:0] dvd_q;      // dividend bits shift out the top, quotient bits in the bottom
  logic [31:0] rem_q;
  logic [31:0] divisor_q;
  logic [31:0] step_rem;
  logic        step_q;
  logic        accept;
  logic        div_by_zero;
  logic [31:0] dvd_in, divisor_in;
  logic [31:0] quot_fin, rem_fin;
  logic        stall;
  logic        ready;
  double_reg_t result;

  assign accept      = (bus.start_i == DIV_START) & ~bus.annul_i;
  assign div_by_zero = (bus.opdata2_i == ZERO_WORD);

`ifdef DIV_SIGNED_EN
  logic neg_quot_q, neg_rem_q;
  logic a_neg, b_neg;

  assign a_neg      = bus.signed_i & bus.opdata1_i[31];
  assign b_neg      = bus.signed_i & bus.opdata2_i[31];
  assign dvd_in     = a_neg ? neg32(bus.opdata1_i) : bus.opdata1_i;
  assign divisor_in = b_neg ? neg32(bus.opdata2_i) : bus.opdata2_i;
  assign quot_fin   = neg_quot_q ? neg32(dvd_q) : dvd_q;
  assign rem_fin    = neg_rem_q  ? neg32(rem_q) : rem_q;

  // Divide-by-zero returns raw bits, so its sign flags are cleared.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
    end else if (state_q == DIV_IDLE && accept) begin
      neg_quot_q <= ~div_by_zero & (a_neg ^ b_neg);
      neg_rem_q  <= ~div_by_zero & a_neg;
    end
  end
`else
  logic unused_signed;
  assign unused_signed = bus.signed_i;
  assign dvd_in        = bus.opdata1_i;
  assign divisor_in    = bus.opdata2_i;
  assign quot_fin      = dvd_q;
  assign rem_fin       = rem_q;
`endif

  div_step u_step (
    .rem_i     (rem_q),
    .bit_i     (dvd_q[31]),
    .divisor_i (divisor_q),
    .rem_o     (step_rem),
    .q_o       (step_q)
  );

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q   <= DIV_IDLE;
      cnt_q     <= '0;
      dvd_q     <= '0;
      rem_q     <= '0;
      divisor_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        DIV_IDLE: begin
          if (accept) begin
            cnt_q <= '0;
            if (div_by_zero) begin
              dvd_q <= '1;
              rem_q <= bus.opdata1_i;
            end else begin
              dvd_q     <= dvd_in;
              rem_q     <= '0;
              divisor_q <= divisor_in;
            end
          end
        end
        DIV_ON: begin
          dvd_q <= {dvd_q[30:0], step_q};
          rem_q <= step_rem;
          cnt_q <= cnt_q + 5'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    stall   = STALLREQ_DISABLE;
    ready   = DIV_RESULT_NOT_READY;
    result  = '0;
    case (state_q)
      DIV_IDLE: begin
        if (accept) begin
          stall   = STALLREQ_ENABLE;
          state_d = div_by_zero ? DIV_DIVZERO : DIV_ON;
        end
      end
      DIV_DIVZERO: begin
        if (bus.annul_i) begin
          state_d = DIV_IDLE;
        end else begin
          stall   = STALLREQ_ENABLE;
          state_d = DIV_END;
        end
      end
      DIV_ON: begin
        if (bus.annul_i) begin
          state_d = DIV_IDLE;
        end else begin
          stall = STALLREQ_ENABLE;
          if (cnt_q == LAST_STEP) state_d = DIV_END;
        end
      end
      DIV_END: begin
        state_d = DIV_IDLE;
        if (!bus.annul_i) begin
          ready  = DIV_RESULT_READY;
          result = {rem_fin, quot_fin};
        end
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  assign bus.stallreq_o = stall;
  assign bus.ready_o    = ready;
  assign bus.result_o   = result;

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: self-checking bench for div_seq.
// Table vectors, hand sequences (annul mid-ON, reset mid-ON, annul in IDLE)
// and random operands checked against an arithmetic reference model.
// Expected values follow DIV_SIGNED_EN the same way the design does.
module tb_div_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_seq_if bus ();

  div_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct {
    bit          sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  // Plain-arithmetic reference: SV division truncates toward zero and the
  // remainder takes the dividend's sign, which is the MIPS DIV behaviour.
  function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    bit use_signed;
    use_signed = sgn;
`ifndef DIV_SIGNED_EN
    use_signed = 1'b0;
`endif
    if (b == 32'h0) return {a, 32'hFFFF_FFFF};
    if (use_signed) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'h0, a});
      sb = longint'({32'h0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Called just after a negedge with the DUT in IDLE. Holds start while the
  // DUT stalls, returns shortly after the negedge following the ready pulse.
  task automatic run_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                         output logic [63:0] res, output int lat, output int stalls);
    bus.start_i   = 1'b1;
    bus.signed_i  = sgn;
    bus.opdata1_i = a;
    bus.opdata2_i = b;
    lat    = -1;
    stalls = 0;
    res    = '0;
    for (int k = 0; k < 60; k++) begin
      #1;
      if (bus.stallreq_o) stalls++;
      if (bus.ready_o) begin
        lat = k;
        res = bus.result_o;
        bus.start_i = 1'b0;
      end
      @(negedge clk);
      if (lat >= 0) break;
    end
    bus.start_i = 1'b0;
    #1;
    check("ready_one_cycle", 64'(bus.ready_o), 64'd0);
  endtask

  task automatic run_and_check(input string tag, input bit sgn, input logic [31:0] a,
                               input logic [31:0] b, input logic [63:0] exp);
    logic [63:0] res;
    int lat, stalls, exp_cyc;
    exp_cyc = (b == 32'h0) ? 2 : 33;
    run_div(sgn, a, b, res, lat, stalls);
    check({tag, "_result"}, res, exp);
    check({tag, "_latency"}, 64'(lat), 64'(exp_cyc));
    check({tag, "_stall_cycles"}, 64'(stalls), 64'(exp_cyc));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] res;
    int lat, stalls, ready_seen;
    logic [31:0] ra, rb;
    bit rs;

    vecs[0] = '{1'b0, 32'd100,        32'd7,        {32'h0000_0002, 32'h0000_000E}};
`ifdef DIV_SIGNED_EN
    vecs[1] = '{1'b1, 32'hFFFF_FF9C,  32'd7,        {32'hFFFF_FFFE, 32'hFFFF_FFF2}};
    vecs[2] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000}};
    vecs[5] = '{1'b1, 32'd7,          32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD}};
`else
    vecs[1] = '{1'b1, 32'hFFFF_FF9C,  32'd7,        {32'h0000_0002, 32'h2492_4916}};
    vecs[2] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF, {32'h8000_0000, 32'h0000_0000}};
    vecs[5] = '{1'b1, 32'd7,          32'hFFFF_FFFE, {32'h0000_0007, 32'h0000_0000}};
`endif
    vecs[3] = '{1'b0, 32'd5,          32'd0,        {32'h0000_0005, 32'hFFFF_FFFF}};
    vecs[4] = '{1'b0, 32'hFFFF_FFFF,  32'd1,        {32'h0000_0000, 32'hFFFF_FFFF}};
    vecs[6] = '{1'b1, 32'hFFFF_FFF9,  32'd0,        {32'hFFFF_FFF9, 32'hFFFF_FFFF}};

    rst = 1'b1;
    bus.start_i   = 1'b0;
    bus.signed_i  = 1'b0;
    bus.opdata1_i = '0;
    bus.opdata2_i = '0;
    bus.annul_i   = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_result", bus.result_o, 64'd0);
    check("reset_ready", 64'(bus.ready_o), 64'd0);
    check("reset_stall", 64'(bus.stallreq_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Start blocked by annul in IDLE: no stall, and nothing gets accepted.
    bus.start_i   = 1'b1;
    bus.annul_i   = 1'b1;
    bus.opdata1_i = 32'd50;
    bus.opdata2_i = 32'd5;
    #1;
    check("idle_annul_stall", 64'(bus.stallreq_o), 64'd0);
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.annul_i = 1'b0;
    #1;
    check("idle_annul_not_accepted", 64'(bus.stallreq_o), 64'd0);
    @(negedge clk);

    // Table vectors, issued back to back (next start in the IDLE after END).
    for (int i = 0; i < 7; i++)
      run_and_check($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp);

    // Annul at T+10 mid-ON, then DIVU 9/3 started at T+11.
    bus.start_i   = 1'b1;
    bus.signed_i  = 1'b0;
    bus.opdata1_i = 32'd100;
    bus.opdata2_i = 32'd7;
    ready_seen = 0;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (bus.ready_o) ready_seen++;
      @(negedge clk);
    end
    bus.annul_i = 1'b1;
    bus.start_i = 1'b0;
    #1;
    check("annul_stall_drop", 64'(bus.stallreq_o), 64'd0);
    check("annul_no_ready", 64'(bus.ready_o | (ready_seen != 0)), 64'd0);
    @(negedge clk);
    bus.annul_i = 1'b0;
    run_and_check("after_annul", 1'b0, 32'd9, 32'd3, {32'h0, 32'h3});

    // Reset at T+20 mid-ON.
    bus.start_i   = 1'b1;
    bus.signed_i  = 1'b0;
    bus.opdata1_i = 32'd1000;
    bus.opdata2_i = 32'd3;
    for (int k = 0; k < 20; k++) @(negedge clk);
    rst = 1'b1;
    bus.start_i = 1'b0;
    @(negedge clk);
    #1;
    check("midrst_result", bus.result_o, 64'd0);
    check("midrst_ready", 64'(bus.ready_o), 64'd0);
    check("midrst_stall", 64'(bus.stallreq_o), 64'd0);
    rst = 1'b0;
    ready_seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      #1;
      if (bus.ready_o) ready_seen++;
    end
    check("midrst_no_ready_pulse", 64'(ready_seen), 64'd0);
    @(negedge clk);

    // Random operands against the reference model.
    for (int i = 0; i < 40; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      case ($urandom_range(0, 4))
        0: rb = 32'($urandom_range(1, 15));
        1: rb = 32'h0;
        2: begin rb = $urandom; ra = 32'h8000_0000; end
        3: rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        default: rb = $urandom;
      endcase
      run_and_check($sformatf("rand%0d", i), rs, ra, rb, ref_div(rs, ra, rb));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
